ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
Downstream consumer of the PS/2 receiver's 8-bit scan-code output, running in the system clock domain. It resynchronises the receiver's byte strobe and parses Set-2 prefix sequences (E0 extended, F0 break). It emits one key event per complete make or break sequence through a small FIFO with a valid/ready interface. It also tracks shift, ctrl and alt modifier state for the character-mapping stage.

Parameters:
FIFO_DEPTH, 8, event FIFO entries (power of two, 2..16)
TIMEOUT_CYCLES, 2_500_000, clock cycles a prefix may wait for its next byte before the parser abandons it
SYNC_STAGES, 2, flip-flop stages on the strobe synchroniser (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
scan_byte  in  8  received byte from the PS/2 receiver (ps2_clock domain, stable while strobe is high)
scan_strobe  in  1  high for at least one ps2_clock period when scan_byte is valid (ps2_clock domain)
event_valid  out  1  FIFO head holds an event
event_ready  in  1  consumer accepts the head event when high together with event_valid
event_code  out  8  scan code of the head event (prefixes stripped)
event_extended  out  1  head event was E0-prefixed
event_released  out  1  head event is a break (F0-prefixed)
mod_shift  out  1  either shift held (codes 12, 59)
mod_ctrl  out  1  ctrl held (14, or E0 14)
mod_alt  out  1  alt held (11, or E0 11)
overflow  out  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, event_valid=0, event_code/extended/released=0, all mod_*=0, overflow=0, parser in IDLE, timeout counter 0, synchroniser flops 0.
- Strobe path: scan_strobe passes through SYNC_STAGES flops. A rising edge of the synchronised signal produces a one-cycle byte_take pulse. scan_byte is sampled on that pulse (it is stable by protocol). Input 00 is ignored.
- Parser states:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {code, ext=0, rel=0}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> push {code, 1, 0}, go to IDLE.
  - BRK: E0 or F0 -> stay BRK (malformed input, the byte is absorbed); other byte -> push {code, 0, 1}, go to IDLE.
  - EXT_BRK: other byte -> push {code, 1, 1}, go to IDLE; a prefix byte is absorbed.
- Receiver error codes: bytes AA, FA, FE, EE and FF in IDLE are not keys. They are dropped without a push and the parser stays in IDLE.
- Timeout: in any non-IDLE state the counter increments each cycle and clears on byte_take. At TIMEOUT_CYCLES-1 the parser returns to IDLE, the counter clears and nothing is pushed.
- Modifiers: updated in the same cycle the event is pushed, whether or not the FIFO accepts it. A make sets the bit and a break clears it. mod_shift is the OR of internal left and right shift bits.
- FIFO: first-word-fall-through. A push becomes visible on event_* one cycle later. A pop occurs when event_valid && event_ready.
  - Simultaneous push and pop while full: both succeed and count is unchanged.
  - Push while full with no pop: the event is dropped and overflow is set. overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointer.
- Outputs are stable while event_valid=1 and event_ready=0.
- Latency: the first event appears SYNC_STAGES+2 cycles after the final byte's strobe rises, with FIFO empty and no stall.

Test Plan:
- Reset mid-stream: reset asserted while in EXT_BRK with 3 events queued -> next cycle event_valid=0, all mod_*=0, overflow=0; a following byte 1C yields {1C,0,0}.
- Plain make/break: bytes 1C, F0 1C with event_ready=1 -> events {1C,0,0} then {1C,0,1}, each valid for exactly 1 cycle.
- Extended key: E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}. Then E0 14 -> mod_ctrl=1, and E0 F0 14 -> mod_ctrl=0.
- Modifiers: 12, 59, F0 12 -> mod_shift stays 1; F0 59 -> mod_shift=0. 11 -> mod_alt=1.
- FIFO full and overflow: event_ready=0, feed 9 makes (15..1D) with FIFO_DEPTH=8 -> overflow=1. Draining yields 15..1C in order and 1D is absent. Push and pop in the same cycle at full holds count=8.
- Timeout and errors: F0, then no byte for TIMEOUT_CYCLES -> parser back in IDLE, and a following 1C yields {1C,0,0}, not a break. Bytes AA, FE -> no events.

Source files
------------

// File: rtl/ps2_scan_decoder_if.sv
// Key-event stream from the scan decoder to the character-mapping stage.
// Latency: n/a (wires only).
// Backpressure: event_ready from the consumer pops the head event when event_valid is high.
// Ports: event_valid/code/extended/released driven by master, event_ready driven by slave.
interface ps2_scan_decoder_if;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_released;

    modport master (
        output event_valid,
        output event_code,
        output event_extended,
        output event_released,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        input  event_extended,
        input  event_released,
        output event_ready
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Parses Set-2 scan bytes (E0/F0 prefixes) into key events, tracks shift/ctrl/alt state.
// Latency: event visible SYNC_STAGES+2 cycles after the final byte's strobe rises (FIFO empty).
// Backpressure: FWFT event FIFO; when full, new events are dropped and overflow sticks high.
// Ports: clock/reset; scan_byte/scan_strobe from the PS/2 receiver; evt (master) event stream;
//        mod_shift/mod_ctrl/mod_alt modifier levels; overflow sticky drop flag.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           scan_byte,
    input  logic                 scan_strobe,
    ps2_scan_decoder_if.master   evt,
    output logic                 mod_shift,
    output logic                 mod_ctrl,
    output logic                 mod_alt,
    output logic                 overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    // ---------------- strobe synchroniser and edge detect ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   byte_take;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            byte_take   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], scan_strobe};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            byte_take   <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    // scan_byte is held stable by the receiver while its strobe is high,
    // so sampling it directly on byte_take is safe.
    logic byte_vld;
    logic is_prefix;
    logic is_error;
    assign byte_vld  = byte_take && (scan_byte != 8'h00);
    assign is_prefix = (scan_byte == 8'hE0) || (scan_byte == 8'hF0);
    assign is_error  = (scan_byte == 8'hAA) || (scan_byte == 8'hFA) || (scan_byte == 8'hFE) ||
                       (scan_byte == 8'hEE) || (scan_byte == 8'hFF);

    // ---------------- prefix parser ----------------
    state_t          state_q, state_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            push;
    logic            push_ext;
    logic            push_rel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;

        // A prefix left waiting too long (unplugged keyboard, lost byte) is abandoned.
        if (state_q != IDLE) begin
            if (byte_vld) begin
                tmo_d = '0;
            end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TO_W'(1);
            end
        end

        if (byte_vld) begin
            case (state_q)
                IDLE: begin
                    if (scan_byte == 8'hE0)      state_d = EXT;
                    else if (scan_byte == 8'hF0) state_d = BRK;
                    else if (!is_error)          push = 1'b1;
                end
                EXT: begin
                    if (scan_byte == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (scan_byte != 8'hE0) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    if (!is_prefix) begin
                        push     = 1'b1;
                        push_rel = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    if (!is_prefix) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        push_rel = 1'b1;
                        state_d  = IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- modifier tracking ----------------
    // Updated on every parsed event, even one the FIFO drops, so modifier
    // state never diverges from the physical keys.
    logic shift_l_q, shift_r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            mod_ctrl  <= 1'b0;
            mod_alt   <= 1'b0;
        end else if (push) begin
            case (scan_byte)
                8'h12:   shift_l_q <= ~push_rel;
                8'h59:   shift_r_q <= ~push_rel;
                8'h14:   mod_ctrl  <= ~push_rel;
                8'h11:   mod_alt   <= ~push_rel;
                default: ;
            endcase
        end
    end

    assign mod_shift = shift_l_q | shift_r_q;

    // ---------------- event FIFO (first-word-fall-through) ----------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop   = evt.event_valid && evt.event_ready;
    // At full, a simultaneous pop frees the slot being written this cycle.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= {scan_byte, push_ext, push_rel};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    // Fields are forced to zero while empty so reset/idle values are defined.
    logic [9:0] head;
    assign head               = mem[rd_ptr_q];
    assign evt.event_valid    = (count_q != '0);
    assign evt.event_code     = evt.event_valid ? head[9:2] : 8'h00;
    assign evt.event_extended = evt.event_valid ? head[1]   : 1'b0;
    assign evt.event_released = evt.event_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int SYNC_STAGES    = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_byte = 8'h00;
    logic       scan_strobe = 1'b0;
    logic       mod_shift, mod_ctrl, mod_alt, overflow;

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_byte   (scan_byte),
        .scan_strobe (scan_strobe),
        .evt         (bus),
        .mod_shift   (mod_shift),
        .mod_ctrl    (mod_ctrl),
        .mod_alt     (mod_alt),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errs   = 0;

    // Accepted events observed on the bus, as {code, extended, released}.
    logic [9:0] obs [$];
    int         valid_cycles = 0;

    always @(negedge clock) begin
        if (bus.event_valid === 1'b1) valid_cycles++;
        if (bus.event_valid === 1'b1 && bus.event_ready === 1'b1)
            obs.push_back({bus.event_code, bus.event_extended, bus.event_released});
    end

    // One byte: strobe high 4 cycles, low 4 cycles; the event is pushed inside this window.
    task automatic send_byte(input logic [7:0] b);
        scan_byte   = b;
        scan_strobe = 1'b1;
        repeat (4) @(negedge clock);
        scan_strobe = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.event_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.event_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.event_valid); end
        checks++;
        if ({bus.event_code, bus.event_extended, bus.event_released} !== 10'h000) begin
            errs++; $display("FAIL reset_fields got=%h exp=000", {bus.event_code, bus.event_extended, bus.event_released});
        end
        checks++;
        if ({mod_shift, mod_ctrl, mod_alt, overflow} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags got=%b exp=0000", {mod_shift, mod_ctrl, mod_alt, overflow});
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // Strobe rises just after a negedge; the event must appear after the 4th rising edge.
    task automatic test_latency;
        bus.event_ready = 1'b0;
        scan_byte   = 8'h1C;
        scan_strobe = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.event_valid !== 1'b0) begin errs++; $display("FAIL latency_early got=%b exp=0", bus.event_valid); end
        @(negedge clock);
        checks++;
        if (bus.event_valid !== 1'b1 || bus.event_code !== 8'h1C) begin
            errs++; $display("FAIL latency_arrive got valid=%b code=%h exp valid=1 code=1c", bus.event_valid, bus.event_code);
        end
        scan_strobe = 1'b0;
        // Stalled head must hold steady.
        repeat (3) @(negedge clock);
        checks++;
        if (bus.event_valid !== 1'b1 || bus.event_code !== 8'h1C || bus.event_released !== 1'b0) begin
            errs++; $display("FAIL latency_hold got valid=%b code=%h exp valid=1 code=1c", bus.event_valid, bus.event_code);
        end
        bus.event_ready = 1'b1;
        repeat (2) @(negedge clock);
        obs.delete();
    endtask

    task automatic test_make_break;
        bus.event_ready = 1'b1;
        obs.delete();
        valid_cycles = 0;
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (4) @(negedge clock);
        checks++;
        if (obs.size() !== 2) begin errs++; $display("FAIL mb_count got=%0d exp=2", obs.size()); end
        checks++;
        if (obs[0] !== {8'h1C, 2'b00}) begin errs++; $display("FAIL mb_make got=%h exp=%h", obs[0], {8'h1C, 2'b00}); end
        checks++;
        if (obs[1] !== {8'h1C, 2'b01}) begin errs++; $display("FAIL mb_break got=%h exp=%h", obs[1], {8'h1C, 2'b01}); end
        checks++;
        if (valid_cycles !== 2) begin errs++; $display("FAIL mb_valid_cycles got=%0d exp=2", valid_cycles); end
    endtask

    task automatic test_extended;
        bus.event_ready = 1'b1;
        obs.delete();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        repeat (4) @(negedge clock);
        checks++;
        if (obs.size() !== 2 || obs[0] !== {8'h75, 2'b10} || obs[1] !== {8'h75, 2'b11}) begin
            errs++; $display("FAIL ext_events got n=%0d %h %h exp n=2 1d6 1d7", obs.size(), obs[0], obs[1]);
        end
        send_byte(8'hE0); send_byte(8'h14);
        checks++;
        if (mod_ctrl !== 1'b1) begin errs++; $display("FAIL ext_ctrl_make got=%b exp=1", mod_ctrl); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        checks++;
        if (mod_ctrl !== 1'b0) begin errs++; $display("FAIL ext_ctrl_break got=%b exp=0", mod_ctrl); end
    endtask

    task automatic test_modifiers;
        bus.event_ready = 1'b1;
        send_byte(8'h12);
        send_byte(8'h59);
        send_byte(8'hF0); send_byte(8'h12);
        checks++;
        if (mod_shift !== 1'b1) begin errs++; $display("FAIL mod_shift_right_held got=%b exp=1", mod_shift); end
        send_byte(8'hF0); send_byte(8'h59);
        checks++;
        if (mod_shift !== 1'b0) begin errs++; $display("FAIL mod_shift_released got=%b exp=0", mod_shift); end
        send_byte(8'h11);
        checks++;
        if (mod_alt !== 1'b1 || mod_ctrl !== 1'b0) begin
            errs++; $display("FAIL mod_alt got alt=%b ctrl=%b exp alt=1 ctrl=0", mod_alt, mod_ctrl);
        end
        send_byte(8'hF0); send_byte(8'h11);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_overflow;
        bus.event_ready = 1'b0;
        obs.delete();
        for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
        checks++;
        if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++;
        if (bus.event_valid !== 1'b1 || bus.event_code !== 8'h15) begin
            errs++; $display("FAIL ovf_head got valid=%b code=%h exp valid=1 code=15", bus.event_valid, bus.event_code);
        end
        // Push 1E while full, popping in the very cycle it is written.
        scan_byte   = 8'h1E;
        scan_strobe = 1'b1;
        repeat (3) @(negedge clock);
        bus.event_ready = 1'b1;
        @(negedge clock);
        bus.event_ready = 1'b0;
        scan_strobe = 1'b0;
        repeat (4) @(negedge clock);
        bus.event_ready = 1'b1;
        repeat (12) @(negedge clock);
        checks++;
        if (obs.size() !== 9) begin errs++; $display("FAIL ovf_drain_count got=%0d exp=9", obs.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] exp_code;
            exp_code = (i < 8) ? 8'h15 + 8'(i) : 8'h1E;
            checks++;
            if (obs[i] !== {exp_code, 2'b00}) begin
                errs++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, obs[i], {exp_code, 2'b00});
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_timeout_errors;
        bus.event_ready = 1'b1;
        obs.delete();
        send_byte(8'hF0);
        repeat (TIMEOUT_CYCLES + 8) @(negedge clock);
        send_byte(8'h1C);
        repeat (3) @(negedge clock);
        checks++;
        if (obs.size() !== 1 || obs[0] !== {8'h1C, 2'b00}) begin
            errs++; $display("FAIL timeout_event got n=%0d %h exp n=1 070", obs.size(), obs[0]);
        end
        obs.delete();
        send_byte(8'hAA);
        send_byte(8'hFE);
        send_byte(8'h00);
        repeat (3) @(negedge clock);
        checks++;
        if (obs.size() !== 0) begin errs++; $display("FAIL error_codes got n=%0d exp n=0", obs.size()); end
    endtask

    task automatic test_reset_midstream;
        bus.event_ready = 1'b0;
        send_byte(8'h12);
        send_byte(8'h14);
        send_byte(8'h11);
        checks++;
        if ({mod_shift, mod_ctrl, mod_alt} !== 3'b111 || bus.event_valid !== 1'b1) begin
            errs++; $display("FAIL mid_setup got mods=%b valid=%b exp mods=111 valid=1", {mod_shift, mod_ctrl, mod_alt}, bus.event_valid);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.event_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got=%b exp=0", bus.event_valid); end
        checks++;
        if ({mod_shift, mod_ctrl, mod_alt, overflow} !== 4'b0000) begin
            errs++; $display("FAIL mid_flags got=%b exp=0000", {mod_shift, mod_ctrl, mod_alt, overflow});
        end
        reset = 1'b1;
        bus.event_ready = 1'b1;
        obs.delete();
        @(negedge clock);
        send_byte(8'h1C);
        repeat (3) @(negedge clock);
        checks++;
        if (obs.size() !== 1 || obs[0] !== {8'h1C, 2'b00}) begin
            errs++; $display("FAIL mid_after got n=%0d %h exp n=1 070", obs.size(), obs[0]);
        end
    endtask

    initial begin
        bus.event_ready = 1'b0;
        test_reset();
        test_latency();
        test_make_break();
        test_extended();
        test_modifiers();
        test_overflow();
        test_timeout_errors();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
